// File: rtl/cfa_pkg.sv
// ============================================================================
// Module  : cfa_pkg
// Brief   : Shared CFA defaults, width derivations, FSM codes and pixel clamp.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cfa_pkg;

    localparam int c_PW_DEFAULT = 12;
    localparam int c_WW_DEFAULT = 8;

    function automatic int calc_numw(input int pw, input int ww);
        return pw + ww + 2;
    endfunction

    function automatic int calc_divw(input int ww);
        return ww + 1;
    endfunction

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_CALC = 3'd1;
    localparam logic [2:0] c_ST_SEL  = 3'd2;
    localparam logic [2:0] c_ST_DIV  = 3'd3;
    localparam logic [2:0] c_ST_OUT  = 3'd4;

    // Saturate a signed value into the unsigned range [0, 2^pw-1].
    function automatic logic [31:0] clamp_pix(input logic signed [31:0] val, input int pw);
        logic signed [31:0] max_v;
        max_v = (32'sd1 <<< pw) - 32'sd1;
        if (val < 0) begin
            return '0;
        end else if (val > max_v) begin
            return max_v;
        end else begin
            return val;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/green_serial_div.sv
// ============================================================================
// Module  : green_serial_div
// Brief   : Restoring unsigned divider, one quotient bit per cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module green_serial_div #(
    parameter int NUMW = 22,
    parameter int DIVW = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NUMW-1:0] dividend,
    input  logic [DIVW-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [NUMW-1:0] quotient
);

    localparam int c_CNTW = $clog2(NUMW + 1);

    logic [DIVW-1:0] r_rem_q,  w_rem_d;
    logic [NUMW-1:0] r_quot_q, w_quot_d;
    logic [c_CNTW-1:0] r_cnt_q, w_cnt_d;
    logic            r_busy_q, w_busy_d;
    logic            r_done_q, w_done_d;

    logic [DIVW-1:0] w_src_rem;
    logic [NUMW-1:0] w_src_quot;
    logic [DIVW:0]   w_shift;
    logic [DIVW:0]   w_sub;
    logic            w_ge;

    // The start cycle already performs the first step, so a full division
    // finishes NUMW-1 cycles after the load edge.
    always_comb begin
        w_src_rem  = r_busy_q ? r_rem_q  : '0;
        w_src_quot = r_busy_q ? r_quot_q : dividend;
        w_shift    = {w_src_rem, w_src_quot[NUMW-1]};
        w_ge       = (w_shift >= {1'b0, divisor});
        w_sub      = w_shift - {1'b0, divisor};
    end

    always_comb begin
        w_rem_d  = r_rem_q;
        w_quot_d = r_quot_q;
        w_cnt_d  = r_cnt_q;
        w_busy_d = r_busy_q;
        w_done_d = 1'b0;
        if (r_busy_q) begin
            w_rem_d  = w_ge ? w_sub[DIVW-1:0] : w_shift[DIVW-1:0];
            w_quot_d = {w_src_quot[NUMW-2:0], w_ge};
            w_cnt_d  = r_cnt_q - c_CNTW'(1);
            if (r_cnt_q == c_CNTW'(1)) begin
                w_busy_d = 1'b0;
                w_done_d = 1'b1;
            end
        end else if (start) begin
            w_rem_d  = w_ge ? w_sub[DIVW-1:0] : w_shift[DIVW-1:0];
            w_quot_d = {w_src_quot[NUMW-2:0], w_ge};
            w_cnt_d  = c_CNTW'(NUMW - 1);
            w_busy_d = (NUMW > 1);
            w_done_d = (NUMW == 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem_q  <= '0;
            r_quot_q <= '0;
            r_cnt_q  <= '0;
            r_busy_q <= 1'b0;
            r_done_q <= 1'b0;
        end else begin
            r_rem_q  <= w_rem_d;
            r_quot_q <= w_quot_d;
            r_cnt_q  <= w_cnt_d;
            r_busy_q <= w_busy_d;
            r_done_q <= w_done_d;
        end
    end

    assign busy     = r_busy_q;
    assign done     = r_done_q;
    assign quotient = r_quot_q;

endmodule

`default_nettype wire

// File: rtl/green_interp_ctrl.sv
// ============================================================================
// Module  : green_interp_ctrl
// Brief   : Green-at-R/B interpolation sequencer: directional select or
//           weighted average on a shared serial divider. Option macro:
//           GREEN_ROUND_EN (round magnitude half away from zero).
// Revision: 1.0
// ============================================================================
`default_nettype none

module green_interp_ctrl
    import cfa_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH  = c_PW_DEFAULT,
    parameter int WEIGHT_BIT_WIDTH = c_WW_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WEIGHT_BIT_WIDTH-1:0] h,
    input  logic [WEIGHT_BIT_WIDTH-1:0] v,
    input  logic [WEIGHT_BIT_WIDTH-1:0] threshold,
    input  logic signed [PIXEL_BIT_WIDTH:0] Gh,
    input  logic signed [PIXEL_BIT_WIDTH:0] Gv,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PIXEL_BIT_WIDTH-1:0]  green,
    output logic [1:0]                  out_dir
);

    localparam int c_PW   = PIXEL_BIT_WIDTH;
    localparam int c_WW   = WEIGHT_BIT_WIDTH;
    localparam int c_NUMW = calc_numw(c_PW, c_WW);
    localparam int c_DIVW = calc_divw(c_WW);
    localparam int c_CMPW = (2 * c_WW > c_WW + 8) ? 2 * c_WW : c_WW + 8;

    logic [2:0] r_state_q, w_state_d;

    logic [c_WW-1:0]          r_h_q,   w_h_d;
    logic [c_WW-1:0]          r_v_q,   w_v_d;
    logic [c_WW-1:0]          r_thr_q, w_thr_d;
    logic signed [c_PW:0]     r_gh_q,  w_gh_d;
    logic signed [c_PW:0]     r_gv_q,  w_gv_d;
    logic signed [c_NUMW-1:0] r_num_q, w_num_d;
    logic [c_DIVW-1:0]        r_div_q, w_div_d;
    logic [1:0]               r_dir_q, w_dir_d;
    logic [c_PW-1:0]          r_green_q, w_green_d;

    logic [c_CMPW-1:0]        w_lhs_h, w_rhs_h, w_lhs_v, w_rhs_v;
    logic                     w_cond_h, w_cond_v;
    logic signed [c_NUMW-1:0] w_num;
    logic [c_DIVW-1:0]        w_div;
    logic signed [c_PW+1:0]   w_sum, w_avg;
    logic                     w_num_neg;
    logic [c_NUMW-1:0]        w_mag, w_dividend, w_quot;
    logic signed [c_NUMW-1:0] w_q_signed;
    logic                     w_div_start, w_div_busy, w_div_done;

    // Directional tests compare threshold*w against the other weight in 8.8.
    always_comb begin
        w_lhs_h  = c_CMPW'((2 * c_WW)'(r_thr_q) * (2 * c_WW)'(r_h_q));
        w_rhs_h  = c_CMPW'({r_v_q, 8'h00});
        w_lhs_v  = c_CMPW'((2 * c_WW)'(r_thr_q) * (2 * c_WW)'(r_v_q));
        w_rhs_v  = c_CMPW'({r_h_q, 8'h00});
        w_cond_h = (w_lhs_h > w_rhs_h);
        w_cond_v = (w_lhs_v > w_rhs_v);
        w_num    = c_NUMW'(r_gv_q) * $signed(c_NUMW'(r_h_q))
                 + c_NUMW'(r_gh_q) * $signed(c_NUMW'(r_v_q));
        w_div    = c_DIVW'(r_h_q) + c_DIVW'(r_v_q);
        w_sum    = (c_PW + 2)'(r_gh_q) + (c_PW + 2)'(r_gv_q);
        w_avg    = w_sum >>> 1;
    end

    always_comb begin
        w_num_neg = r_num_q[c_NUMW-1];
        w_mag     = w_num_neg ? c_NUMW'(-r_num_q) : c_NUMW'(r_num_q);
`ifdef GREEN_ROUND_EN
        w_dividend = w_mag + c_NUMW'(r_div_q >> 1);
`else
        w_dividend = w_mag;
`endif
        w_q_signed = w_num_neg ? -$signed(w_quot) : $signed(w_quot);
    end

    green_serial_div #(
        .NUMW (c_NUMW),
        .DIVW (c_DIVW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_div_start),
        .dividend (w_dividend),
        .divisor  (r_div_q),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .quotient (w_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE: if (in_valid) w_state_d = c_ST_CALC;
            c_ST_CALC: begin
                if ((w_cond_h ^ w_cond_v) || (w_div == '0)) begin
                    w_state_d = c_ST_SEL;
                end else begin
                    w_state_d = c_ST_DIV;
                end
            end
            c_ST_SEL:  w_state_d = c_ST_OUT;
            c_ST_DIV:  if (w_div_done) w_state_d = c_ST_OUT;
            c_ST_OUT:  if (out_ready) w_state_d = c_ST_IDLE;
            default:   w_state_d = c_ST_IDLE;
        endcase
    end

    // Start only in the first DIV cycle: afterwards the divider is busy or done.
    always_comb begin
        in_ready    = (r_state_q == c_ST_IDLE);
        out_valid   = (r_state_q == c_ST_OUT);
        w_div_start = (r_state_q == c_ST_DIV) && !w_div_busy && !w_div_done;
    end

    always_comb begin
        w_h_d     = r_h_q;
        w_v_d     = r_v_q;
        w_thr_d   = r_thr_q;
        w_gh_d    = r_gh_q;
        w_gv_d    = r_gv_q;
        w_num_d   = r_num_q;
        w_div_d   = r_div_q;
        w_dir_d   = r_dir_q;
        w_green_d = r_green_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (in_valid) begin
                    w_h_d   = h;
                    w_v_d   = v;
                    w_thr_d = threshold;
                    w_gh_d  = Gh;
                    w_gv_d  = Gv;
                end
            end
            c_ST_CALC: begin
                w_num_d = w_num;
                w_div_d = w_div;
                w_dir_d = {w_cond_h, w_cond_v};
            end
            c_ST_SEL: begin
                case (r_dir_q)
                    2'b01:   w_green_d = c_PW'(clamp_pix(32'(r_gh_q), c_PW));
                    2'b10:   w_green_d = c_PW'(clamp_pix(32'(r_gv_q), c_PW));
                    default: w_green_d = c_PW'(clamp_pix(32'(w_avg), c_PW));
                endcase
            end
            c_ST_DIV: begin
                if (w_div_done) begin
                    w_green_d = c_PW'(clamp_pix(32'(w_q_signed), c_PW));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_q     <= '0;
            r_v_q     <= '0;
            r_thr_q   <= '0;
            r_gh_q    <= '0;
            r_gv_q    <= '0;
            r_num_q   <= '0;
            r_div_q   <= '0;
            r_dir_q   <= '0;
            r_green_q <= '0;
        end else begin
            r_h_q     <= w_h_d;
            r_v_q     <= w_v_d;
            r_thr_q   <= w_thr_d;
            r_gh_q    <= w_gh_d;
            r_gv_q    <= w_gv_d;
            r_num_q   <= w_num_d;
            r_div_q   <= w_div_d;
            r_dir_q   <= w_dir_d;
            r_green_q <= w_green_d;
        end
    end

    assign green   = r_green_q;
    assign out_dir = r_dir_q;

endmodule

`default_nettype wire

// File: tb/tb_green_interp_ctrl.sv
// ============================================================================
// Module  : tb_green_interp_ctrl
// Brief   : Directed self-checking bench for green_interp_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_green_interp_ctrl;

`ifdef GREEN_ROUND_EN
    localparam int c_RND = 1;
`else
    localparam int c_RND = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        h, v, threshold;
    logic signed [12:0] gh, gv;
    logic              out_valid;
    logic              out_ready;
    logic [11:0]       green;
    logic [1:0]        out_dir;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    green_interp_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .h         (h),
        .v         (v),
        .threshold (threshold),
        .Gh        (gh),
        .Gv        (gv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .green     (green),
        .out_dir   (out_dir)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Handshake one task, then wait (bounded) for out_valid.
    task automatic issue(input int th, input int tv, input int tthr, input int tgh, input int tgv,
                         output int lat, output int busy_seen);
        @(negedge clk);
        h         = 8'(th);
        v         = 8'(tv);
        threshold = 8'(tthr);
        gh        = 13'(tgh);
        gv        = 13'(tgv);
        in_valid  = 1'b1;
        check_eq("in_ready_at_issue", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        lat       = 0;
        busy_seen = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (dut.w_div_busy) busy_seen = 1;
        end
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_valid_drop"}, 32'(out_valid), 0);
        check_eq({tag, "_ready_back"}, 32'(in_ready), 1);
    endtask

    task automatic run(input string tag, input int th, input int tv, input int tthr,
                       input int tgh, input int tgv,
                       input int exp_green, input int exp_dir, input int exp_lat);
        int lat, busy_seen;
        issue(th, tv, tthr, tgh, tgv, lat, busy_seen);
        check_eq({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check_eq({tag, "_green"}, 32'(green), 32'(exp_green));
        check_eq({tag, "_dir"},   32'(out_dir), 32'(exp_dir));
        accept(tag);
    endtask

    initial begin
        int lat, busy_seen, hits;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        h = '0; v = '0; threshold = '0; gh = '0; gv = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_in_ready",  32'(in_ready), 1);
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_green",     32'(green), 0);
        check_eq("rst_dir",       32'(out_dir), 0);

        // Divide path and direct paths
        run("div_avg",  16, 16, 32, 1000, 2000, 1500, 0, 24);
        run("sel_gv",  200, 10, 64,    5,  777,  777, 2, 2);
        run("sel_gh",   10, 200, 64,  321,    9,  321, 1, 2);
        run("div_mix",  16, 16, 0,   -100,  500,  200, 0, 24);

        // Clamping on both paths
        run("clamp_lo", 16, 16, 0,   -100, -300,    0, 0, 24);
        run("clamp_hi", 16, 16, 0,   4095, 4095, 4095, 0, 24);
        run("sel_neg", 200, 10, 64,     5,   -5,    0, 2, 2);

        // Zero divisor: average without touching the divider
        issue(0, 0, 0, 10, 21, lat, busy_seen);
        check_eq("div0_lat",   32'(lat), 2);
        check_eq("div0_green", 32'(green), 15);
        check_eq("div0_nobusy", 32'(busy_seen), 0);
        accept("div0");
        run("div0_b", 0, 0, 200, 101, 200, 150, 0, 2);

        // Rounding of the quotient magnitude
        run("rnd_half", 1, 1, 0,   0,  3, 1 + c_RND, 0, 24);
        run("rnd_frac", 3, 1, 0, 100, 10, 32 + c_RND, 0, 24);

        // Backpressure: result held, no new task accepted
        out_ready = 1'b0;
        issue(200, 10, 64, 5, 555, lat, busy_seen);
        check_eq("bp_lat", 32'(lat), 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_green", 32'(green), 555);
            check_eq("bp_valid", 32'(out_valid), 1);
            check_eq("bp_in_ready", 32'(in_ready), 0);
        end
        accept("bp");

        // Reset in the middle of a division aborts it
        @(negedge clk);
        h = 8'd16; v = 8'd16; threshold = 8'd0; gh = 13'sd1000; gv = 13'sd2000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("mid_div_busy", 32'(dut.w_div_busy), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_out_valid", 32'(out_valid), 0);
        check_eq("abort_green",     32'(green), 0);
        check_eq("abort_div_idle",  32'(dut.w_div_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 1);
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) hits++;
        end
        check_eq("no_stale_output", 32'(hits), 0);

        run("recover", 16, 16, 32, 1000, 2000, 1500, 0, 24);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
